// File: rtl/riscv_cpu_pkg.sv
// Shared types and constants for the RISC-V core.
// Holds the instruction cache FSM states and the fetch-block geometry.
package riscv_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM_REQ,
    FILL
  } icache_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam int          BLOCK_W      = 128;
  localparam int          WORD_SEL_LSB = 2;
  localparam int          OFFSET_W     = 4;

  function automatic logic [31:0] block_word(
    input logic [BLOCK_W-1:0] blk,
    input logic [1:0]         sel
  );
    return blk[32*sel +: 32];
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// One combinational read port, one synchronous write port.
module icache_line_array
  import riscv_cpu_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = 3,
  parameter int TAG_W      = 25
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [IDX_W-1:0]   i_rd_idx,
  output logic               o_rd_valid,
  output logic [TAG_W-1:0]   o_rd_tag,
  output logic [BLOCK_W-1:0] o_rd_block,
  input  logic               i_wr_en,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [BLOCK_W-1:0] i_wr_block
);

  logic [NUM_BLOCKS-1:0] r_valid;
  logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    r_data [NUM_BLOCKS];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only read through its valid bit.
  always_ff @(posedge CLK) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_block;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_block = r_data[i_rd_idx];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache feeding the IF/ID register.
// Zero-latency hits; misses refill one 128-bit block from memory.
module instruction_cache
  import riscv_cpu_pkg::*;
#(
  parameter int NUM_BLOCKS = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        ADDRESS,
  input  logic               READ,
  output logic [31:0]        INSTRUCTION,
  output logic               BUSY_WAIT,
  output logic               MEM_READ,
  output logic [27:0]        MEM_ADDRESS,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT
);

  localparam int IDX_W   = $clog2(NUM_BLOCKS);
  localparam int MADDR_W = 32 - OFFSET_W;
  localparam int TAG_W   = MADDR_W - IDX_W;

  icache_state_t r_state;
  icache_state_t w_next;

  logic [MADDR_W-1:0] r_miss_addr;
  logic               w_latch;
  logic               w_we;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [1:0]         w_word;
  logic               w_valid;
  logic [TAG_W-1:0]   w_rd_tag;
  logic [BLOCK_W-1:0] w_rd_block;
  logic               w_hit;
  logic               w_unused;

  assign w_idx    = ADDRESS[OFFSET_W +: IDX_W];
  assign w_tag    = ADDRESS[31 -: TAG_W];
  assign w_word   = ADDRESS[WORD_SEL_LSB +: 2];
  assign w_unused = ^ADDRESS[1:0];

  icache_line_array #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_lines (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_block (w_rd_block),
    .i_wr_en    (w_we),
    .i_wr_idx   (r_miss_addr[IDX_W-1:0]),
    .i_wr_tag   (r_miss_addr[MADDR_W-1 -: TAG_W]),
    .i_wr_block (MEM_READDATA)
  );

  assign w_hit = READ & w_valid & (w_rd_tag == w_tag);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state     <= IDLE;
      r_miss_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_miss_addr <= ADDRESS[31:OFFSET_W];
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_latch     = 1'b0;
    w_we        = 1'b0;
    BUSY_WAIT   = 1'b0;
    MEM_READ    = 1'b0;
    MEM_ADDRESS = '0;
    INSTRUCTION = NOP_INSTR;
    if (RESET) begin
      MEM_ADDRESS = r_miss_addr;
      unique case (r_state)
        IDLE: begin
          if (w_hit) begin
            INSTRUCTION = block_word(w_rd_block, w_word);
          end else if (READ) begin
            BUSY_WAIT = 1'b1;
            w_latch   = 1'b1;
            w_next    = MEM_REQ;
          end
        end
        MEM_REQ: begin
          BUSY_WAIT = 1'b1;
          MEM_READ  = 1'b1;
          if (!MEM_BUSYWAIT) begin
            w_we   = 1'b1;
            w_next = FILL;
          end
        end
        FILL: begin
          BUSY_WAIT = 1'b1;
          w_next    = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a latency-programmable memory.
// Block b word w of memory = 0x00500093 ^ {b[21:0], w, 8'h00}.
module tb_instruction_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  ADDRESS;
  logic         READ;
  logic [31:0]  INSTRUCTION;
  logic         BUSY_WAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int n_chk = 0;
  int n_err = 0;
  int lat   = 5;
  int mcnt  = 0;
  int pulses = 0;
  logic        prev_mr = 1'b0;
  logic [27:0] last_ma = '0;

  instruction_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .READ         (READ),
    .INSTRUCTION  (INSTRUCTION),
    .BUSY_WAIT    (BUSY_WAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [127:0] mblk(input logic [27:0] b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) begin
      r[32*w +: 32] = 32'h0050_0093 ^ {b[21:0], 2'(w), 8'h00};
    end
    return r;
  endfunction

  // Memory: MEM_BUSYWAIT drops on the lat-th cycle of a request.
  always @(posedge CLK) begin
    #1;
    if (MEM_READ === 1'b1) begin
      MEM_BUSYWAIT = (mcnt != lat - 1);
      mcnt++;
    end else begin
      mcnt = 0;
      MEM_BUSYWAIT = 1'b1;
    end
    MEM_READDATA = mblk(MEM_ADDRESS);
  end

  always @(posedge CLK) begin
    #3;
    if (MEM_READ === 1'b1 && prev_mr !== 1'b1) begin
      pulses++;
      last_ma = MEM_ADDRESS;
    end
    prev_mr = MEM_READ;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr,
                       input int exp_busy, input logic [31:0] exp_ins,
                       input logic [27:0] exp_ma);
    int n;
    int p0;
    p0 = pulses;
    ADDRESS = addr;
    READ = 1'b1;
    #1;
    n = 0;
    while (BUSY_WAIT === 1'b1 && n < 60) begin
      if (n == 0) chk({tag, "_nop"}, INSTRUCTION, 32'h13);
      n++;
      @(negedge CLK);
      #1;
    end
    chk({tag, "_busy"}, 32'(n), 32'(exp_busy));
    chk({tag, "_ins"}, INSTRUCTION, exp_ins);
    chk({tag, "_pulses"}, 32'(pulses - p0), (exp_busy > 0) ? 32'd1 : 32'd0);
    if (exp_busy > 0) chk({tag, "_maddr"}, {4'h0, last_ma}, {4'h0, exp_ma});
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    READ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic idle_chk(input string tag);
    #1;
    chk({tag, "_bw"}, {31'h0, BUSY_WAIT}, 32'h0);
    chk({tag, "_mr"}, {31'h0, MEM_READ}, 32'h0);
    chk({tag, "_ins"}, INSTRUCTION, 32'h13);
  endtask

  initial begin
    int n;
    RESET = 1'b0;
    READ = 1'b1;
    ADDRESS = 32'h0;
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = '0;
    @(negedge CLK);
    @(negedge CLK);
    idle_chk("rst");
    chk("rst_ma", {4'h0, MEM_ADDRESS}, 32'h0);
    RESET = 1'b1;

    // 1: cold miss, M=5
    lat = 5;
    fetch("t1", 32'h0, 7, 32'h0050_0093, 28'h0);

    // 2: same-line hits, then next line misses
    fetch("t2_04", 32'h4, 0, 32'h0050_0193, 28'h0);
    fetch("t2_08", 32'h8, 0, 32'h0050_0293, 28'h0);
    fetch("t2_0c", 32'hC, 0, 32'h0050_0393, 28'h0);
    lat = 2;
    fetch("t2_10", 32'h10, 4, 32'h0050_0493, 28'h1);

    // 3: conflicting tag on index 0, M=1
    lat = 1;
    fetch("t3_80", 32'h80, 3, 32'h0050_2093, 28'h8);
    fetch("t3_00", 32'h0, 3, 32'h0050_0093, 28'h0);
    fetch("t3_10", 32'h10, 0, 32'h0050_0493, 28'h0);
    chk("pulses_total", 32'(pulses), 32'd4);

    // 4: reset during MEM_REQ cycle 2
    do_reset();
    lat = 5;
    @(negedge CLK);
    ADDRESS = 32'h0;
    READ = 1'b1;
    #1;
    chk("t4_miss", {31'h0, BUSY_WAIT}, 32'h1);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("t4_req", {31'h0, MEM_READ}, 32'h1);
    RESET = 1'b0;
    idle_chk("t4_inrst");
    @(negedge CLK);
    RESET = 1'b1;
    READ = 1'b0;
    idle_chk("t4_after");
    @(negedge CLK);
    fetch("t4_refetch", 32'h0, 7, 32'h0050_0093, 28'h0);

    // 5: address moves mid-refill; refill stays on the latched line
    do_reset();
    @(negedge CLK);
    ADDRESS = 32'h0;
    READ = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    ADDRESS = 32'h40;
    #1;
    chk("t5_ma", {4'h0, MEM_ADDRESS}, 32'h0);
    n = 0;
    while (MEM_READ === 1'b1 && n < 30) begin
      n++;
      @(negedge CLK);
      #1;
    end
    chk("t5_fill_bw", {31'h0, BUSY_WAIT}, 32'h1);
    chk("t5_req_left", 32'(n), 32'd4);
    @(negedge CLK);
    fetch("t5_hit0", 32'h0, 0, 32'h0050_0093, 28'h0);
    fetch("t5_40", 32'h40, 7, 32'h0050_1093, 28'h4);
    fetch("t5_again0", 32'h0, 0, 32'h0050_0093, 28'h0);

    // 6: no fetch request
    n = pulses;
    ADDRESS = 32'hFFFF_FFFC;
    READ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle_chk("t6_top");
      @(negedge CLK);
    end
    ADDRESS = 32'h0;
    idle_chk("t6_valid");
    @(negedge CLK);
    chk("t6_pulses", 32'(pulses - n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
